// File: rtl/cpu_pkg.sv
// Shared pipeline types and widths for the 16-bit five-stage core.
package cpu_pkg;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 16;
  localparam int REG_ADDR_W = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  // MEM/WB pipeline slot, also consumed by the writeback stage.
  typedef struct packed {
    logic                  valid;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     read_data;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: bubble clears the slot, load captures d, otherwise hold.
module mem_wb_reg
  import cpu_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    load,
  input  logic    bubble,
  input  mem_wb_t d,
  output mem_wb_t q
);

  mem_wb_t slot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else if (bubble) begin
      slot_q <= '0;
    end else if (load) begin
      slot_q <= d;
    end
  end

  assign q = slot_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: req/ready data-memory handshake feeding the MEM/WB register.
// Optional access timeout with mem_fault output is enabled by MEM_STAGE_TIMEOUT_EN.
module mem_stage #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic [DATA_W-1:0]     ex_alu_result,
  input  logic [DATA_W-1:0]     ex_store_data,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  ex_mem_to_reg,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_stall,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic                  dmem_ready,
  input  logic [DATA_W-1:0]     dmem_rdata,
`ifdef MEM_STAGE_TIMEOUT_EN
  output logic                  mem_fault,
`endif
  output logic                  mem_wb_valid,
  output logic [DATA_W-1:0]     mem_wb_alu_result,
  output logic [DATA_W-1:0]     mem_wb_read_data,
  output logic                  mem_wb_mem_to_reg,
  output logic                  mem_wb_reg_write,
  output logic [REG_ADDR_W-1:0] mem_wb_rd
);

  import cpu_pkg::*;

  mem_state_t            state_q, state_d;
  logic [DATA_W-1:0]     alu_q, alu_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  mem_to_reg_q, mem_to_reg_d;
  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;

  mem_wb_t wb_next;
  mem_wb_t wb_q;
  logic    wb_load;
  logic    wb_bubble;

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
`endif

  always_comb begin
    state_d      = state_q;
    alu_d        = alu_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    mem_to_reg_d = mem_to_reg_q;
    reg_write_d  = reg_write_q;
    rd_d         = rd_q;
    wb_next      = '0;
    wb_load      = 1'b0;
    wb_bubble    = 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
    cnt_d        = cnt_q;
    fault_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (ex_valid && (ex_mem_read || ex_mem_write)) begin
          // A store wins when both read and write are flagged.
          alu_d        = ex_alu_result;
          wdata_d      = ex_store_data;
          we_d         = ex_mem_write;
          mem_to_reg_d = ex_mem_to_reg;
          reg_write_d  = ex_reg_write;
          rd_d         = ex_rd;
          state_d      = ACCESS;
          wb_bubble    = 1'b1;
`ifdef MEM_STAGE_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end else if (ex_valid) begin
          wb_load            = 1'b1;
          wb_next.valid      = 1'b1;
          wb_next.alu_result = ex_alu_result;
          wb_next.mem_to_reg = ex_mem_to_reg;
          wb_next.reg_write  = ex_reg_write;
          wb_next.rd         = ex_rd;
        end else begin
          wb_bubble = 1'b1;
        end
      end
      ACCESS: begin
        if (dmem_ready) begin
          wb_load            = 1'b1;
          wb_next.valid      = 1'b1;
          wb_next.alu_result = alu_q;
          wb_next.read_data  = we_q ? '0 : dmem_rdata;
          wb_next.mem_to_reg = mem_to_reg_q;
          wb_next.reg_write  = reg_write_q;
          wb_next.rd         = rd_q;
          state_d            = IDLE;
        end
`ifdef MEM_STAGE_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = IDLE;
          wb_bubble = 1'b1;
          fault_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      alu_q        <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
`ifdef MEM_STAGE_TIMEOUT_EN
      cnt_q        <= '0;
      fault_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      alu_q        <= alu_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      rd_q         <= rd_d;
`ifdef MEM_STAGE_TIMEOUT_EN
      cnt_q        <= cnt_d;
      fault_q      <= fault_d;
`endif
    end
  end

  // Decoded straight from state so they fall with an asynchronous reset.
  assign mem_stall  = (state_q == ACCESS);
  assign dmem_req   = (state_q == ACCESS);
  assign dmem_we    = (state_q == ACCESS) && we_q;
  assign dmem_addr  = (state_q == ACCESS) ? alu_q[ADDR_W-1:0] : '0;
  assign dmem_wdata = (state_q == ACCESS) ? wdata_q : '0;

`ifdef MEM_STAGE_TIMEOUT_EN
  assign mem_fault = fault_q;
`endif

  mem_wb_reg u_mem_wb_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (wb_load),
    .bubble (wb_bubble),
    .d      (wb_next),
    .q      (wb_q)
  );

  assign mem_wb_valid      = wb_q.valid;
  assign mem_wb_alu_result = wb_q.alu_result;
  assign mem_wb_read_data  = wb_q.read_data;
  assign mem_wb_mem_to_reg = wb_q.mem_to_reg;
  assign mem_wb_reg_write  = wb_q.reg_write;
  assign mem_wb_rd         = wb_q.rd;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; covers the timeout path when MEM_STAGE_TIMEOUT_EN is defined.
module tb_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [15:0] ex_alu_result;
  logic [15:0] ex_store_data;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic        ex_reg_write;
  logic [2:0]  ex_rd;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ready;
  logic [15:0] dmem_rdata;
  logic        mem_wb_valid;
  logic [15:0] mem_wb_alu_result;
  logic [15:0] mem_wb_read_data;
  logic        mem_wb_mem_to_reg;
  logic        mem_wb_reg_write;
  logic [2:0]  mem_wb_rd;
`ifdef MEM_STAGE_TIMEOUT_EN
  logic        mem_fault;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // {valid, alu_result, read_data, mem_to_reg, reg_write, rd}
  logic [37:0] wb_bus, exp_wb;
  // {mem_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata}
  logic [34:0] mem_bus, exp_mem;

  assign wb_bus  = {mem_wb_valid, mem_wb_alu_result, mem_wb_read_data,
                    mem_wb_mem_to_reg, mem_wb_reg_write, mem_wb_rd};
  assign mem_bus = {mem_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata};

  mem_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ex_valid          (ex_valid),
    .ex_alu_result     (ex_alu_result),
    .ex_store_data     (ex_store_data),
    .ex_mem_read       (ex_mem_read),
    .ex_mem_write      (ex_mem_write),
    .ex_mem_to_reg     (ex_mem_to_reg),
    .ex_reg_write      (ex_reg_write),
    .ex_rd             (ex_rd),
    .mem_stall         (mem_stall),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_ready        (dmem_ready),
    .dmem_rdata        (dmem_rdata),
`ifdef MEM_STAGE_TIMEOUT_EN
    .mem_fault         (mem_fault),
`endif
    .mem_wb_valid      (mem_wb_valid),
    .mem_wb_alu_result (mem_wb_alu_result),
    .mem_wb_read_data  (mem_wb_read_data),
    .mem_wb_mem_to_reg (mem_wb_mem_to_reg),
    .mem_wb_reg_write  (mem_wb_reg_write),
    .mem_wb_rd         (mem_wb_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [15:0] alu, input logic [15:0] sd,
                          input logic rd_en, input logic wr_en, input logic m2r,
                          input logic rw, input logic [2:0] rd);
    ex_valid      = v;
    ex_alu_result = alu;
    ex_store_data = sd;
    ex_mem_read   = rd_en;
    ex_mem_write  = wr_en;
    ex_mem_to_reg = m2r;
    ex_reg_write  = rw;
    ex_rd         = rd;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    dmem_ready = 1'b0;
    dmem_rdata = 16'h0;
    drive_ex(1'b1, 16'h4321, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
    #2;
    exp_wb = '0;
    n_checks++;
    if (wb_bus !== exp_wb) begin
      n_fail++; $display("FAIL reset_wb: got %h expected %h", wb_bus, exp_wb);
    end
    step;
    exp_mem = '0;
    n_checks++;
    if (mem_bus !== exp_mem || wb_bus !== exp_wb) begin
      n_fail++; $display("FAIL reset_held: mem %h wb %h expected 0", mem_bus, wb_bus);
    end
`ifdef MEM_STAGE_TIMEOUT_EN
    n_checks++;
    if (mem_fault !== 1'b0) begin
      n_fail++; $display("FAIL reset_fault: got %b expected 0", mem_fault);
    end
`endif
    drive_ex(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    #3 rst_n = 1'b1;
    step;
    $display("reset: outputs checked low, released");
  endtask

  task automatic test_alu;
    drive_ex(1'b1, 16'h1234, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5);
    dmem_ready = 1'b1;
    dmem_rdata = 16'hFFFF;
    step;
    exp_wb = {1'b1, 16'h1234, 16'h0000, 1'b0, 1'b1, 3'd5};
    n_checks++;
    if (wb_bus !== exp_wb) begin
      n_fail++; $display("FAIL alu_wb: got %h expected %h", wb_bus, exp_wb);
    end
    exp_mem = '0;
    n_checks++;
    if (mem_bus !== exp_mem) begin
      n_fail++; $display("FAIL alu_no_stall: got %h expected %h", mem_bus, exp_mem);
    end
    dmem_ready = 1'b0;
    drive_ex(1'b1, 16'h00FF, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7);
    step;
    exp_wb = {1'b1, 16'h00FF, 16'h0000, 1'b0, 1'b0, 3'd7};
    n_checks++;
    if (wb_bus !== exp_wb) begin
      n_fail++; $display("FAIL alu_second_wb: got %h expected %h", wb_bus, exp_wb);
    end
    drive_ex(1'b0, 16'hDEAD, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2);
    step;
    exp_wb = '0;
    n_checks++;
    if (wb_bus !== exp_wb) begin
      n_fail++; $display("FAIL alu_bubble: got %h expected %h", wb_bus, exp_wb);
    end
    $display("alu: two single-cycle ops then bubble");
  endtask

  task automatic test_load_zero_wait;
    drive_ex(1'b1, 16'h0040, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2);
    step;
    exp_mem = {1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000};
    n_checks++;
    if (mem_bus !== exp_mem) begin
      n_fail++; $display("FAIL load_req: got %h expected %h", mem_bus, exp_mem);
    end
    exp_wb = '0;
    n_checks++;
    if (wb_bus !== exp_wb) begin
      n_fail++; $display("FAIL load_accept_bubble: got %h expected %h", wb_bus, exp_wb);
    end
    drive_ex(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    dmem_ready = 1'b1;
    dmem_rdata = 16'hBEEF;
    step;
    dmem_ready = 1'b0;
    exp_wb = {1'b1, 16'h0040, 16'hBEEF, 1'b1, 1'b1, 3'd2};
    n_checks++;
    if (wb_bus !== exp_wb) begin
      n_fail++; $display("FAIL load_wb: got %h expected %h", wb_bus, exp_wb);
    end
    exp_mem = '0;
    n_checks++;
    if (mem_bus !== exp_mem) begin
      n_fail++; $display("FAIL load_release: got %h expected %h", mem_bus, exp_mem);
    end
    $display("load: addr 0040 -> BEEF zero-wait");
  endtask

  task automatic test_store_wait;
    drive_ex(1'b1, 16'h0010, 16'hA5A5, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    step;
    drive_ex(1'b1, 16'h7777, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6);
    exp_mem = {1'b1, 1'b1, 1'b1, 16'h0010, 16'hA5A5};
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i == 3);
      dmem_rdata = 16'hCCCC;
      n_checks++;
      if (mem_bus !== exp_mem || mem_wb_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL store_wait%0d: mem %h wb_valid %b expected %h / 0", i, mem_bus, mem_wb_valid, exp_mem);
      end
      step;
    end
    dmem_ready = 1'b0;
    exp_wb = {1'b1, 16'h0010, 16'h0000, 1'b0, 1'b0, 3'd0};
    n_checks++;
    if (wb_bus !== exp_wb) begin
      n_fail++; $display("FAIL store_wb: got %h expected %h", wb_bus, exp_wb);
    end
    // The held ALU op now passes in the following cycle.
    step;
    exp_wb = {1'b1, 16'h7777, 16'h0000, 1'b0, 1'b1, 3'd6};
    n_checks++;
    if (wb_bus !== exp_wb) begin
      n_fail++; $display("FAIL store_next_op: got %h expected %h", wb_bus, exp_wb);
    end
    drive_ex(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    step;
    $display("store: A5A5 -> 0010 with 3 wait states");
  endtask

  task automatic test_back_to_back;
    drive_ex(1'b1, 16'h0020, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1);
    step;
    drive_ex(1'b1, 16'h5555, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3);
    dmem_ready = 1'b1;
    dmem_rdata = 16'h1111;
    step;
    dmem_ready = 1'b0;
    exp_wb = {1'b1, 16'h0020, 16'h1111, 1'b1, 1'b1, 3'd1};
    n_checks++;
    if (wb_bus !== exp_wb) begin
      n_fail++; $display("FAIL b2b_load: got %h expected %h", wb_bus, exp_wb);
    end
    step;
    exp_wb = {1'b1, 16'h5555, 16'h0000, 1'b0, 1'b1, 3'd3};
    n_checks++;
    if (wb_bus !== exp_wb) begin
      n_fail++; $display("FAIL b2b_alu: got %h expected %h", wb_bus, exp_wb);
    end
    drive_ex(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    step;
    exp_wb = '0;
    n_checks++;
    if (wb_bus !== exp_wb) begin
      n_fail++; $display("FAIL b2b_no_dup: got %h expected %h", wb_bus, exp_wb);
    end
    $display("back_to_back: load then alu, no loss or duplicate");
  endtask

  task automatic test_read_write_both;
    drive_ex(1'b1, 16'h0030, 16'h0F0F, 1'b1, 1'b1, 1'b1, 1'b1, 3'd4);
    step;
    drive_ex(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    exp_mem = {1'b1, 1'b1, 1'b1, 16'h0030, 16'h0F0F};
    n_checks++;
    if (mem_bus !== exp_mem) begin
      n_fail++; $display("FAIL rw_both_req: got %h expected %h", mem_bus, exp_mem);
    end
    dmem_ready = 1'b1;
    dmem_rdata = 16'hFFFF;
    step;
    dmem_ready = 1'b0;
    exp_wb = {1'b1, 16'h0030, 16'h0000, 1'b1, 1'b1, 3'd4};
    n_checks++;
    if (wb_bus !== exp_wb) begin
      n_fail++; $display("FAIL rw_both_wb: got %h expected %h", wb_bus, exp_wb);
    end
    $display("rw_both: treated as store to 0030");
  endtask

  task automatic test_reset_mid_access;
    drive_ex(1'b1, 16'h0050, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 3'd6);
    step;
    drive_ex(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    dmem_ready = 1'b0;
    step;
    #2 rst_n = 1'b0;
    #1;
    exp_mem = '0;
    exp_wb  = '0;
    n_checks++;
    if (mem_bus !== exp_mem || wb_bus !== exp_wb) begin
      n_fail++; $display("FAIL async_reset: mem %h wb %h expected 0", mem_bus, wb_bus);
    end
    #2 rst_n = 1'b1;
    drive_ex(1'b1, 16'h0777, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5);
    step;
    exp_wb = {1'b1, 16'h0777, 16'h0000, 1'b0, 1'b1, 3'd5};
    n_checks++;
    if (wb_bus !== exp_wb || mem_stall !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_alu: wb %h stall %b expected %h / 0", wb_bus, mem_stall, exp_wb);
    end
    drive_ex(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    step;
    $display("reset_mid_access: access abandoned, alu op passes after");
  endtask

`ifdef MEM_STAGE_TIMEOUT_EN
  task automatic test_timeout;
    drive_ex(1'b1, 16'h0060, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2);
    step;
    drive_ex(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    dmem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      n_checks++;
      if (mem_fault !== 1'b0 || mem_stall !== 1'b1) begin
        n_fail++; $display("FAIL timeout_wait%0d: fault %b stall %b expected 0 / 1", i, mem_fault, mem_stall);
      end
      step;
    end
    exp_mem = '0;
    exp_wb  = '0;
    n_checks++;
    if (mem_fault !== 1'b1 || mem_bus !== exp_mem || wb_bus !== exp_wb) begin
      n_fail++; $display("FAIL timeout_abort: fault %b mem %h wb %h expected 1 / 0 / 0", mem_fault, mem_bus, wb_bus);
    end
    step;
    n_checks++;
    if (mem_fault !== 1'b0) begin
      n_fail++; $display("FAIL timeout_pulse: got %b expected 0", mem_fault);
    end
    $display("timeout: abort after 15 access cycles");
  endtask
`endif

  initial begin
    test_reset;
    test_alu;
    test_load_zero_wait;
    test_store_wait;
    test_back_to_back;
    test_read_write_both;
    test_reset_mid_access;
`ifdef MEM_STAGE_TIMEOUT_EN
    test_timeout;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 16-bit five-stage pipeline. It is the producer of the MEM/WB pipeline register that the writeback stage consumes.
- Takes EX/MEM results, performs loads and stores over a req/ready data-memory handshake, and stalls upstream while an access is outstanding.
- Drives a registered MEM/WB bundle: ALU result, read data, MemToReg, RegWrite and destination register.

Parameters:
- DATA_W, 16, datapath and memory data width
- ADDR_W, 16, data-memory address width (taken from the low bits of the ALU result)
- REG_ADDR_W, 3, destination register index width
- TIMEOUT, 15, max cycles in ACCESS before abort (used only with the optional feature)

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX/MEM slot holds a real instruction
- ex_alu_result  in  DATA_W  ALU result / effective address
- ex_store_data  in  DATA_W  store data
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_mem_to_reg  in  1  writeback selects memory data
- ex_reg_write  in  1  instruction writes the register file
- ex_rd  in  REG_ADDR_W  destination register
- mem_stall  out  1  hold EX/MEM and all earlier stages
- dmem_req  out  1  memory request
- dmem_we  out  1  1=write, 0=read
- dmem_addr  out  ADDR_W  access address
- dmem_wdata  out  DATA_W  write data
- dmem_ready  in  1  memory completes the access this cycle
- dmem_rdata  in  DATA_W  read data, valid when dmem_ready=1
- mem_wb_valid  out  1  MEM/WB slot valid
- mem_wb_alu_result  out  DATA_W  registered ALU result
- mem_wb_read_data  out  DATA_W  registered load data (0 for non-loads)
- mem_wb_mem_to_reg  out  1  registered MemToReg
- mem_wb_reg_write  out  1  registered RegWrite (forced 0 when mem_wb_valid=0)
- mem_wb_rd  out  REG_ADDR_W  registered destination register

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all mem_wb_* outputs = 0; hold registers = 0; dmem_req=0 and mem_stall=0 immediately, without waiting for a clock edge. Reset mid-ACCESS abandons the access; memory must tolerate the dropped req.
- FSM states: IDLE, ACCESS.
- IDLE, ex_valid=1, no memory op:
  - next edge loads MEM/WB from the ex_* inputs, read_data=0, valid=1.
  - latency 1 cycle, one instruction per cycle.
- IDLE, ex_valid=0: next edge writes a bubble (valid=0, reg_write=0, other fields 0).
- IDLE, ex_valid=1 with mem_read or mem_write:
  - capture address, wdata, we, ctrl and rd into hold registers; go to ACCESS.
  - MEM/WB gets a bubble at this edge.
- ACCESS:
  - dmem_req=1; dmem_we, dmem_addr and dmem_wdata come from the hold registers and stay stable until ready.
  - mem_stall=1 for every ACCESS cycle, including the ready cycle. ex_* inputs are ignored while stalled.
- ACCESS with dmem_ready=1:
  - next edge loads MEM/WB from the hold registers, valid=1.
  - read_data = dmem_rdata for loads, 0 for stores.
  - state returns to IDLE.
- ACCESS with dmem_ready=0: hold state; MEM/WB keeps its prior contents.
- Memory-op latency: 2 cycles minimum (zero-wait memory), plus one cycle per wait state.
- Outside ACCESS: dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
- mem_read and mem_write both 1: treated as a store; read_data=0.
- dmem_ready while in IDLE: ignored.
- dmem_addr = ex_alu_result[ADDR_W-1:0] as captured at the accept edge.

Optional Feature:
- Macro MEM_STAGE_TIMEOUT_EN.
- When defined:
  - a counter clears on entry to ACCESS and increments each ACCESS cycle.
  - if it reaches TIMEOUT without dmem_ready, return to IDLE and write a bubble into MEM/WB.
  - extra output mem_fault pulses 1 cycle at the abort edge; reset value 0.
- When undefined: no counter and no mem_fault port; ACCESS waits indefinitely.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W, ADDR_W, REG_ADDR_W constants.
  - mem_state_t enum {IDLE, ACCESS}.
  - packed struct mem_wb_t {valid, alu_result, read_data, mem_to_reg, reg_write, rd}, also used by the writeback stage.
- One sub-module, mem_wb_reg:
  - the async-reset MEM/WB register with load and bubble controls.
  - FSM, hold registers and handshake remain in mem_stage.

Test Plan:
- ADD result 0x1234 to rd=5, reg_write=1 → next cycle mem_wb_valid=1, alu_result=0x1234, read_data=0, rd=5; mem_stall never asserted.
- Load from addr 0x0040, memory returns 0xBEEF with zero waits → dmem_req high 1 cycle with addr 0x0040, we=0; mem_stall high 1 cycle; MEM/WB read_data=0xBEEF, mem_to_reg=1, two cycles after accept.
- Store 0xA5A5 to 0x0010 with 3 wait states → dmem_req/we/addr/wdata stable 4 cycles; mem_stall 4 cycles; then MEM/WB valid with reg_write=0, read_data=0.
- Back-to-back load then ALU op → ALU op enters MEM/WB exactly one cycle after the load result; no instruction lost or duplicated.
- rst_n low during the 2nd wait cycle of a load → dmem_req and mem_stall drop the same cycle; all mem_wb_* outputs = 0; after release, a new ALU op passes normally.
- With MEM_STAGE_TIMEOUT_EN and TIMEOUT=15, memory never ready → mem_fault pulses after 15 ACCESS cycles; MEM/WB gets a bubble; state returns to IDLE.
